pixel_feeder: RTL and testbench

Upstream stage of face_detection. Accepts a free-running camera pixel stream (one 16-bit pixel per valid cycle, start-of-frame marked), buffers it in a small FIFO, and issues one-pixel transfers to the detector using its ready / recieve_pixel / end handshake. Tracks frame position, reports frame completion, and flags overflow and frame-sync errors so the host can discard corrupted frames.

---
 rtl/pixel_feeder.sv | 173 +++++++++++++++++
 tb/tb_pixel_feeder.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_feeder.sv
// pixel_feeder: buffers a non-stallable camera pixel stream in a small FIFO
// and hands pixels one at a time to the face detector over its
// ready / recieve_pixel / end handshake. It tracks the frame position of the
// next pixel to send and flags overflow and frame-sync errors.
module pixel_feeder #(
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int FRAME_WIDTH  = 800,
  parameter int FRAME_HEIGHT = 600,
  parameter int COORD_WIDTH  = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic                   i_sof,
  input  logic [DATA_WIDTH-1:0]  i_pixel,
  input  logic                   fpga_ready_recieve_pixel,
  input  logic                   recieve_pixel_end,
  output logic                   o_recieve_pixel,
  output logic [DATA_WIDTH-1:0]  o_pixel,
  output logic [COORD_WIDTH-1:0] o_x,
  output logic [COORD_WIDTH-1:0] o_y,
  output logic                   o_frame_done,
  output logic                   o_overflow,
  output logic                   o_sync_error,
  output logic [ADDR_WIDTH:0]    o_fifo_level
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]    LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [COORD_WIDTH-1:0] X_LAST     = COORD_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST     = COORD_WIDTH'(FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {
    SYNC,
    WAIT_READY,
    SEND,
    WAIT_ACK
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH:0]    mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]    level_q, level_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overflow_q, overflow_d;
  logic                   sync_error_q, sync_error_d;

  logic                   full, empty, push, pop;
  logic                   head_sof;
  logic [DATA_WIDTH-1:0]  head_pixel;

  assign full       = (level_q == LEVEL_FULL);
  assign empty      = (level_q == '0);
  // Full is judged on the registered level, so a push in a pop cycle is still dropped.
  assign push       = i_valid && !full && ((state_q != SYNC) || i_sof);
  assign head_sof   = mem_q[rd_ptr_q][DATA_WIDTH];
  assign head_pixel = mem_q[rd_ptr_q][DATA_WIDTH-1:0];

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // FSM next-state: lock onto SOF, then one strobe per ready, wait for the ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:       if (push)                                 state_d = WAIT_READY;
      WAIT_READY: if (!empty && fpga_ready_recieve_pixel)   state_d = SEND;
      SEND:                                                 state_d = WAIT_ACK;
      WAIT_ACK:   if (recieve_pixel_end)                    state_d = WAIT_READY;
      default:                                              state_d = SYNC;
    endcase
  end

  // FSM outputs: strobe and pop are both tied to the single SEND cycle.
  always_comb begin
    o_recieve_pixel = 1'b0;
    o_pixel         = '0;
    pop             = 1'b0;
    if (state_q == SEND) begin
      o_recieve_pixel = 1'b1;
      o_pixel         = head_pixel;
      pop             = 1'b1;
    end
  end

  // FIFO storage, written with the SOF tag alongside the pixel.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_sof, i_pixel};
  end

  // Datapath next-state: pointers, occupancy, frame position and sticky flags.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d      = level_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | (i_valid && full);
    sync_error_d = sync_error_q;

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A misplaced SOF restarts the frame at the pixel being sent; a missing
    // SOF at the frame origin is only reported.
    if (state_q == SEND) begin
      if (head_sof && ((x_q != '0) || (y_q != '0))) begin
        sync_error_d = 1'b1;
        x_d          = '0;
        y_d          = '0;
      end else if (!head_sof && (x_q == '0) && (y_q == '0)) begin
        sync_error_d = 1'b1;
      end
    end

    if ((state_q == WAIT_ACK) && recieve_pixel_end) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d          = '0;
          frame_done_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      sync_error_q <= sync_error_d;
    end
  end

  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_frame_done = frame_done_q;
  assign o_overflow   = overflow_q;
  assign o_sync_error = sync_error_q;
  assign o_fifo_level = level_q;

endmodule

// File: tb/tb_pixel_feeder.sv
// Testbench for pixel_feeder on a 4x3 frame with a 16-entry FIFO.
// The stimulus thread predicts which camera pixels enter the FIFO and queues
// them; a monitor thread pops the queue on every strobe, tracks the frame
// position as a linear index, and plays the detector side of the handshake.
module tb_pixel_feeder;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int W     = 4;
  localparam int H     = 3;
  localparam int CW    = 12;

  logic          clk;
  logic          reset;
  logic          i_valid;
  logic          i_sof;
  logic [DW-1:0] i_pixel;
  logic          ready;
  logic          ack;
  logic          o_recieve_pixel;
  logic [DW-1:0] o_pixel;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic          o_frame_done;
  logic          o_overflow;
  logic          o_sync_error;
  logic [AW:0]   o_fifo_level;

  pixel_feeder #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_WIDTH  (AW),
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .COORD_WIDTH (CW)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .i_valid                  (i_valid),
    .i_sof                    (i_sof),
    .i_pixel                  (i_pixel),
    .fpga_ready_recieve_pixel (ready),
    .recieve_pixel_end        (ack),
    .o_recieve_pixel          (o_recieve_pixel),
    .o_pixel                  (o_pixel),
    .o_x                      (o_x),
    .o_y                      (o_y),
    .o_frame_done             (o_frame_done),
    .o_overflow               (o_overflow),
    .o_sync_error             (o_sync_error),
    .o_fifo_level             (o_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            sof;
    logic [DW-1:0] pix;
  } ent_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t expq[$];

  // stimulus-side model
  int npush;
  bit synced;
  bit ovf_exp;
  // monitor-side model
  int npop;
  int pos;
  bit sync_exp;
  bit fd_exp;
  bit pend_pop;
  bit pend_sof;
  bit pend_ack;
  bit awaiting;
  int cyc;
  int last_strobe;
  bit have_last;
  int nstrobe;
  int nfd;
  // detector behaviour: 0 ready low, 1 ready always high,
  // 2 ready dropped per transfer then re-raised, 3 ready high but never acks
  int det_mode;
  int raise_min;
  int raise_max;
  bit det_busy;
  bit ack_due;
  int raise_cnt;
  bit check_spacing;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic clear_stim_model();
    expq.delete();
    npush   = 0;
    synced  = 1'b0;
    ovf_exp = 1'b0;
  endtask

  // Drives one cycle of camera input and predicts whether the FIFO takes it.
  task automatic drive(input bit v, input bit s, input logic [DW-1:0] p);
    ent_t e;
    @(negedge clk);
    #1;
    i_valid = v;
    i_sof   = s;
    i_pixel = p;
    if (v) begin
      if (npush - npop == DEPTH) begin
        ovf_exp = 1'b1;
      end else if (synced || s) begin
        e.sof = s;
        e.pix = p;
        expq.push_back(e);
        npush++;
        synced = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_pixel = '0;
    clear_stim_model();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (!(expq.size() == 0 && npush == npop && !awaiting) && guard < 3000) begin
      idle(1);
      guard++;
    end
    if (guard >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d queued, expected 0", expq.size());
    end
    idle(4);
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) idle($urandom_range(max_gap, 1));
      drive(1'b1, (i == 0), base + DW'(i));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobe"}, int'(o_recieve_pixel), 0);
    check({tag, "_pixel"},  int'(o_pixel), 0);
    check({tag, "_x"},      int'(o_x), 0);
    check({tag, "_y"},      int'(o_y), 0);
    check({tag, "_done"},   int'(o_frame_done), 0);
    check({tag, "_ovf"},    int'(o_overflow), 0);
    check({tag, "_sync"},   int'(o_sync_error), 0);
    check({tag, "_level"},  int'(o_fifo_level), 0);
  endtask

  initial begin
    int s0;
    int f0;
    ent_t e;
    reset = 1'b0;
    i_valid = 1'b0;
    i_sof = 1'b0;
    i_pixel = '0;
    ready = 1'b0;
    ack = 1'b0;
    det_mode = 0;
    raise_min = 2;
    raise_max = 2;
    check_spacing = 1'b0;
    nstrobe = 0;
    nfd = 0;
    cyc = 0;
    npop = 0;
    clear_stim_model();

    fork
      // monitor + detector
      forever begin
        @(negedge clk);
        cyc++;
        if (!reset) begin
          npop = 0; pos = 0; sync_exp = 0; fd_exp = 0;
          pend_pop = 0; pend_ack = 0; awaiting = 0; have_last = 0;
          det_busy = 0; ack_due = 0; raise_cnt = 0;
          ready = 1'b0; ack = 1'b0;
        end else begin
          fd_exp = 1'b0;
          if (pend_pop) begin
            npop++;
            if (pend_sof) begin
              if (pos != 0) begin
                sync_exp = 1'b1;
                pos = 0;
              end
            end else if (pos == 0) begin
              sync_exp = 1'b1;
            end
            pend_pop = 1'b0;
          end
          if (pend_ack) begin
            pos = (pos + 1) % (W * H);
            if (pos == 0) fd_exp = 1'b1;
            awaiting = 1'b0;
            pend_ack = 1'b0;
          end
          check("x",          int'(o_x), pos % W);
          check("y",          int'(o_y), pos / W);
          check("frame_done", int'(o_frame_done), int'(fd_exp));
          check("sync_error", int'(o_sync_error), int'(sync_exp));
          check("overflow",   int'(o_overflow), int'(ovf_exp));
          check("fifo_level", int'(o_fifo_level), npush - npop);
          if (o_frame_done) nfd++;
          if (o_recieve_pixel) begin
            nstrobe++;
            check("strobe_without_ack", int'(awaiting), 0);
            if (check_spacing && have_last) check("strobe_spacing", cyc - last_strobe, 3);
            last_strobe = cyc;
            have_last = 1'b1;
            awaiting = 1'b1;
            if (expq.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_strobe: got pixel 0x%0h, expected no strobe", o_pixel);
            end else begin
              e = expq.pop_front();
              check("pixel", int'(o_pixel), int'(e.pix));
              pend_pop = 1'b1;
              pend_sof = e.sof;
            end
          end
          ack = 1'b0;
          if (raise_cnt > 0) begin
            raise_cnt--;
            if (raise_cnt == 0) det_busy = 1'b0;
          end
          if (ack_due) begin
            ack = 1'b1;
            pend_ack = 1'b1;
            ack_due = 1'b0;
            raise_cnt = $urandom_range(raise_max, raise_min);
          end
          if (o_recieve_pixel) begin
            det_busy = 1'b1;
            ack_due = (det_mode != 3);
          end
          case (det_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = !det_busy;
          endcase
        end
      end
      // watchdog
      begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state, then one clean frame with ready re-raised 2 cycles after ack
    apply_reset();
    check_all_zero("reset");
    det_mode = 2; raise_min = 2; raise_max = 2;
    s0 = nstrobe; f0 = nfd;
    send_frame(16'h0100, 12, 0);
    drain();
    check("A_strobes", nstrobe - s0, 12);
    check("A_frame_done_count", nfd - f0, 1);
    check("A_x_end", int'(o_x), 0);
    check("A_y_end", int'(o_y), 0);

    // leading pixels without SOF are discarded while syncing
    apply_reset();
    det_mode = 2; raise_min = 1; raise_max = 3;
    s0 = nstrobe;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0AA0 + DW'(i));
    check("B_level_sync", int'(o_fifo_level), 0);
    send_frame(16'h0200, 12, 2);
    drain();
    check("B_strobes", nstrobe - s0, 12);
    check("B_sync_error", int'(o_sync_error), 0);

    // overflow: ready low, 20 back-to-back pixels into a 16-deep FIFO
    apply_reset();
    det_mode = 0;
    s0 = nstrobe;
    send_frame(16'h0300, 20, 0);
    idle(2);
    check("C_level_full", int'(o_fifo_level), DEPTH);
    check("C_overflow", int'(o_overflow), 1);
    det_mode = 2; raise_min = 1; raise_max = 2;
    drain();
    check("C_strobes", nstrobe - s0, DEPTH);

    // ready held high: strobes every 3 cycles, then a random stream
    apply_reset();
    det_mode = 0;
    s0 = nstrobe;
    send_frame(16'h0400, 12, 0);
    idle(2);
    check_spacing = 1'b1;
    det_mode = 1;
    drain();
    check_spacing = 1'b0;
    check("D_strobes", nstrobe - s0, 12);
    for (int f = 0; f < 3; f++) send_frame(DW'($urandom_range(16'hFFFF, 0)), 12, 4);
    drain();

    // SOF injected at the fifth pixel restarts the frame
    apply_reset();
    det_mode = 2; raise_min = 1; raise_max = 3;
    f0 = nfd;
    send_frame(16'h0500, 4, 1);
    send_frame(16'h0600, 12, 1);
    drain();
    check("E_sync_error", int'(o_sync_error), 1);
    check("E_frame_done_count", nfd - f0, 1);
    check("E_x_end", int'(o_x), 0);
    check("E_y_end", int'(o_y), 0);

    // asynchronous reset while waiting for the ack with 5 entries queued
    apply_reset();
    det_mode = 0;
    send_frame(16'h0700, 6, 0);
    idle(2);
    check("F_level_before", int'(o_fifo_level), 6);
    s0 = nstrobe;
    det_mode = 3;
    for (int i = 0; i < 20 && nstrobe == s0; i++) idle(1);
    check("F_strobe_seen", nstrobe - s0, 1);
    @(posedge clk);
    #2;
    check("F_level_wait_ack", int'(o_fifo_level), 5);
    reset = 1'b0;
    #1;
    check_all_zero("F_async");
    apply_reset();
    det_mode = 2;
    s0 = nstrobe;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0800 + DW'(i));
    idle(3);
    check("F_sync_after_reset_level", int'(o_fifo_level), 0);
    check("F_no_strobe_after_reset", nstrobe - s0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
